// File: rtl/q2_sequencer.sv
// Q2 CPU major-state sequencer: fetch/load/deref/exec/ALU steps,
// two-phase write strobe and front-panel run/stop/step control.
module q2_sequencer #(
  parameter bit START_RUN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_sw,
  input  logic stop_sw,
  input  logic step_sw,
  input  logic op1,
  input  logic op2,
  input  logic op5,
  input  logic halt,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic ws,
  output logic running,
  output logic idle
);

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

  phase_t     phase_q, phase_d;
  logic [3:0] s_q, s_d;
  logic       running_q, running_d;
  logic       stepping_q, stepping_d;
  logic [2:0] run_sync_q, run_sync_d;
  logic [2:0] step_sync_q, step_sync_d;
  logic [1:0] stop_sync_q, stop_sync_d;

  logic       run_pulse;
  logic       step_pulse;
  logic       stop_s;
  logic       idle_w;
  logic       exec_halt;
  logic [3:0] s_next;

  assign run_pulse  = run_sync_q[1] & ~run_sync_q[2];
  assign step_pulse = step_sync_q[1] & ~step_sync_q[2];
  assign stop_s     = stop_sync_q[1];

  assign idle_w = (s_q == 4'd0) && (phase_q == PH_A)
                  && !running_q && !stepping_q;

  assign exec_halt = (s_q == 4'd3) && halt;

  always_comb begin
    s_next = s_q + 4'd1;
    case (s_q)
      4'd0:    s_next = op2 ? 4'd1 : (op1 ? 4'd2 : 4'd3);
      4'd1:    s_next = op1 ? 4'd2 : 4'd3;
      4'd2:    s_next = 4'd3;
      4'd3:    s_next = (op5 || halt) ? 4'd0 : 4'd4;
      4'd15:   s_next = 4'd0;
      default: s_next = s_q + 4'd1;
    endcase
  end

  always_comb begin
    run_sync_d  = {run_sync_q[1:0], run_sw};
    step_sync_d = {step_sync_q[1:0], step_sw};
    stop_sync_d = {stop_sync_q[0], stop_sw};
    phase_d     = phase_q;
    s_d         = s_q;
    running_d   = running_q;
    stepping_d  = stepping_q;

    if (run_pulse && !stop_s && !running_q)
      running_d = 1'b1;
    else if (step_pulse && idle_w)
      stepping_d = 1'b1;

    if (phase_q == PH_B) begin
      phase_d = PH_A;
      s_d     = s_next;
      if (s_next == 4'd0) begin
        stepping_d = 1'b0;
        if (stop_s) running_d = 1'b0;
      end
      if (exec_halt) begin
        running_d  = 1'b0;
        stepping_d = 1'b0;
      end
    end else if (s_q != 4'd0 || running_q || stepping_q) begin
      // parked fetch phase A holds until a flag is set
      phase_d = PH_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= START_RUN ? PH_A : PH_A;
      s_q         <= 4'd0;
      running_q   <= START_RUN;
      stepping_q  <= 1'b0;
      run_sync_q  <= 3'd0;
      step_sync_q <= 3'd0;
      stop_sync_q <= 2'd0;
    end else begin
      phase_q     <= phase_d;
      s_q         <= s_d;
      running_q   <= running_d;
      stepping_q  <= stepping_d;
      run_sync_q  <= run_sync_d;
      step_sync_q <= step_sync_d;
      stop_sync_q <= stop_sync_d;
    end
  end

  assign s0      = s_q[0];
  assign s1      = s_q[1];
  assign s2      = s_q[2];
  assign s3      = s_q[3];
  assign ws      = (phase_q == PH_B);
  assign running = running_q;
  assign idle    = idle_w;

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed bench for q2_sequencer: reset, run, step, halt, stop
// and mid-instruction reset, checked with immediate assertions.
module tb_q2_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic run_sw, stop_sw, step_sw;
  logic op1, op2, op5, halt;
  logic s0, s1, s2, s3, ws, running, idle;

  int n_cmp = 0;
  int n_err = 0;

  q2_sequencer #(.START_RUN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .run_sw(run_sw), .stop_sw(stop_sw), .step_sw(step_sw),
    .op1(op1), .op2(op2), .op5(op5), .halt(halt),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .ws(ws), .running(running), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] cur_s();
    return {s3, s2, s1, s0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sw(input string tag,
                        input logic [3:0] es,
                        input logic ew);
    chk({tag, "_s"}, {4'd0, cur_s()}, {4'd0, es});
    chk({tag, "_ws"}, {7'd0, ws}, {7'd0, ew});
  endtask

  task automatic wait_sw(input string tag,
                         input logic [3:0] es,
                         input logic ew);
    int n = 0;
    while (!(cur_s() == es && ws == ew) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {7'd0, n < 200}, 8'd1);
  endtask

  // run pulse timing: sampled at E0, running after E2, ws after E3
  task automatic start_run();
    run_sw = 1'b1;
    tick();
    chk("run_e0", {7'd0, running}, 8'd0);
    tick();
    chk("run_e1", {7'd0, running}, 8'd0);
    tick();
    chk("run_e2", {7'd0, running}, 8'd1);
    chk_sw("run_e2", 4'd0, 1'b0);
    run_sw = 1'b0;
    tick();
    chk_sw("run_e3", 4'd0, 1'b1);
  endtask

  task automatic do_step();
    step_sw = 1'b1;
    tick();
    tick();
    chk("step_e1_idle", {7'd0, idle}, 8'd1);
    tick();
    chk("step_e2_idle", {7'd0, idle}, 8'd0);
    chk_sw("step_e2", 4'd0, 1'b0);
    step_sw = 1'b0;
    tick();
    chk_sw("step_e3", 4'd0, 1'b1);
    tick();
    chk_sw("step_e4", 4'd3, 1'b0);
    tick();
    chk_sw("step_e5", 4'd3, 1'b1);
    tick();
    chk_sw("step_e6", 4'd0, 1'b0);
    chk("step_idle", {7'd0, idle}, 8'd1);
    chk("step_run", {7'd0, running}, 8'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_sw("step_hold", 4'd0, 1'b0);
      chk("step_hold_idle", {7'd0, idle}, 8'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    run_sw = 0; stop_sw = 0; step_sw = 0;
    op1 = 0; op2 = 0; op5 = 0; halt = 0;
    #23;
    chk_sw("rst_async", 4'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk_sw("reset_idle", 4'd0, 1'b0);
      chk("reset_idle_i", {7'd0, idle}, 8'd1);
      chk("reset_run", {7'd0, running}, 8'd0);
    end

    op2 = 1; op1 = 1; op5 = 0;
    start_run();
    for (int k = 1; k < 16; k++) begin
      tick();
      chk_sw("inst1_a", k[3:0], 1'b0);
      tick();
      chk_sw("inst1_b", k[3:0], 1'b1);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      chk_sw("inst2_a", k[3:0], 1'b0);
      tick();
      chk_sw("inst2_b", k[3:0], 1'b1);
    end

    wait_sw("wait_s7", 4'd7, 1'b0);
    stop_sw = 1'b1;
    tick();
    chk_sw("stop_s7b", 4'd7, 1'b1);
    for (int k = 8; k < 16; k++) begin
      tick();
      chk_sw("stop_a", k[3:0], 1'b0);
      tick();
      chk_sw("stop_b", k[3:0], 1'b1);
    end
    tick();
    chk_sw("stop_end", 4'd0, 1'b0);
    chk("stop_idle", {7'd0, idle}, 8'd1);
    chk("stop_run", {7'd0, running}, 8'd0);
    run_sw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stop_runign", {7'd0, running}, 8'd0);
      chk("stop_ws", {7'd0, ws}, 8'd0);
    end
    run_sw = 1'b0;
    stop_sw = 1'b0;
    repeat (4) tick();

    op2 = 0; op1 = 0; op5 = 1;
    do_step();
    repeat (3) tick();
    do_step();

    op2 = 0; op1 = 0; op5 = 0;
    start_run();
    tick();
    chk_sw("halt_e4", 4'd3, 1'b0);
    halt = 1'b1;
    tick();
    chk_sw("halt_e5", 4'd3, 1'b1);
    chk("halt_e5_run", {7'd0, running}, 8'd1);
    tick();
    halt = 1'b0;
    chk_sw("halt_e6", 4'd0, 1'b0);
    chk("halt_run", {7'd0, running}, 8'd0);
    chk("halt_idle", {7'd0, idle}, 8'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_nows", {7'd0, ws}, 8'd0);
    end

    op2 = 1; op1 = 1; op5 = 0;
    start_run();
    wait_sw("wait_s9b", 4'd9, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_sw("rst_mid", 4'd0, 1'b0);
    chk("rst_mid_run", {7'd0, running}, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rel_idle", {7'd0, idle}, 8'd1);
    run_sw = 1'b1;
    step_sw = 1'b1;
    tick();
    tick();
    tick();
    chk("both_run", {7'd0, running}, 8'd1);
    chk("both_step", {7'd0, dut.stepping_q}, 8'd0);
    run_sw = 1'b0;
    step_sw = 1'b0;
    tick();
    chk_sw("both_e3", 4'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
